// File: rtl/input_debouncer.sv
// Input conditioner: a synchroniser chain followed by a four-state filter. The
// filter only changes clean_out once the synchronised level has held for STABLE_CYCLES cycles.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    async_in,
  input  logic                    glitch_clear,
  output logic                    clean_out,
  output logic                    busy,
  output logic [GLITCH_WIDTH-1:0] glitch_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW:0]           STABLE_TGT = (CW + 1)'(STABLE_CYCLES);
  localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    ST_LOW        = 2'd0,
    ST_CHECK_HIGH = 2'd1,
    ST_HIGH       = 2'd2,
    ST_CHECK_LOW  = 2'd3
  } state_t;

  // Synchroniser chain: stage 0 samples the raw input, and the last stage is the filtered source.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = async_in;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign sync = sync_reg[SYNC_STAGES-1];

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [CW:0]             cnt_inc;
  logic                    glitch_event;
  logic                    clean_out_reg, clean_out_next;
  logic                    busy_reg, busy_next;
  logic [GLITCH_WIDTH-1:0] glitch_count_reg, glitch_count_next;

  // One extra bit so the comparison against STABLE_CYCLES cannot overflow.
  assign cnt_inc = {1'b0, cnt_reg} + (CW + 1)'(1);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    glitch_event = 1'b0;
    case (state_reg)
      ST_LOW: begin
        if (sync) begin
          if (STABLE_CYCLES == 1) begin
            state_next = ST_HIGH;
          end else begin
            state_next = ST_CHECK_HIGH;
            cnt_next   = CW'(1);
          end
        end
      end
      ST_CHECK_HIGH: begin
        if (!sync) begin
          state_next   = ST_LOW;
          cnt_next     = '0;
          glitch_event = 1'b1;
        end else if (cnt_inc == STABLE_TGT) begin
          state_next = ST_HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc[CW-1:0];
        end
      end
      ST_HIGH: begin
        if (!sync) begin
          if (STABLE_CYCLES == 1) begin
            state_next = ST_LOW;
          end else begin
            state_next = ST_CHECK_LOW;
            cnt_next   = CW'(1);
          end
        end
      end
      ST_CHECK_LOW: begin
        if (sync) begin
          state_next   = ST_HIGH;
          cnt_next     = '0;
          glitch_event = 1'b1;
        end else if (cnt_inc == STABLE_TGT) begin
          state_next = ST_LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc[CW-1:0];
        end
      end
      default: begin
        state_next = ST_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state, so they move on the same edge as the state.
  always_comb begin
    clean_out_next = (state_next == ST_HIGH) || (state_next == ST_CHECK_LOW);
    busy_next      = (state_next == ST_CHECK_HIGH) || (state_next == ST_CHECK_LOW);
  end

  // A clear that coincides with a glitch leaves the new glitch counted.
  always_comb begin
    glitch_count_next = glitch_count_reg;
    if (glitch_clear) begin
      glitch_count_next = glitch_event ? GLITCH_WIDTH'(1) : '0;
    end else if (glitch_event && (glitch_count_reg != GLITCH_MAX)) begin
      glitch_count_next = glitch_count_reg + GLITCH_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_LOW;
      cnt_reg          <= '0;
      clean_out_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      glitch_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      clean_out_reg    <= clean_out_next;
      busy_reg         <= busy_next;
      glitch_count_reg <= glitch_count_next;
    end
  end

  assign clean_out    = clean_out_reg;
  assign busy         = busy_reg;
  assign glitch_count = glitch_count_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: DUT a uses STABLE_CYCLES=4, and DUT b uses STABLE_CYCLES=1.
// Expectations are queued per edge and compared one cycle later.
module tb_input_debouncer;

  logic       clk;
  logic       reset;
  logic       a_in, a_clr, a_clean, a_busy;
  logic [1:0] a_gc;
  logic       b_in, b_clr, b_clean, b_busy;
  logic [1:0] b_gc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         dut;
    logic       clean;
    logic       busy;
    logic [1:0] gc;
  } exp_t;

  exp_t sb[$];

  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_WIDTH(2)) dut_a (
    .clk(clk), .reset(reset), .async_in(a_in), .glitch_clear(a_clr),
    .clean_out(a_clean), .busy(a_busy), .glitch_count(a_gc)
  );

  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .async_in(b_in), .glitch_clear(b_clr),
    .clean_out(b_clean), .busy(b_busy), .glitch_count(b_gc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input string tag, input int dut, input logic c,
                             input logic b, input logic [1:0] g);
    exp_t e;
    e.tag = tag; e.dut = dut; e.clean = c; e.busy = b; e.gc = g;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t       e;
    logic       oc, ob;
    logic [1:0] og;
    e  = sb.pop_front();
    oc = (e.dut == 0) ? a_clean : b_clean;
    ob = (e.dut == 0) ? a_busy  : b_busy;
    og = (e.dut == 0) ? a_gc    : b_gc;
    checks++;
    assert (oc === e.clean) else begin
      failures++;
      $error("FAIL %s clean_out observed=%b expected=%b", e.tag, oc, e.clean);
    end
    checks++;
    assert (ob === e.busy) else begin
      failures++;
      $error("FAIL %s busy observed=%b expected=%b", e.tag, ob, e.busy);
    end
    checks++;
    assert (og === e.gc) else begin
      failures++;
      $error("FAIL %s glitch_count observed=%0d expected=%0d", e.tag, og, e.gc);
    end
  endtask

  task automatic step(input string tag, input int dut, input logic c,
                      input logic b, input logic [1:0] g);
    expect_push(tag, dut, c, b, g);
    tick();
    check_next();
  endtask

  initial begin
    reset = 1'b1; a_in = 1'b1; a_clr = 1'b0; b_in = 1'b0; b_clr = 1'b0;

    // Reset is held with a_in high, so all outputs must stay low.
    for (int k = 1; k <= 3; k++) step($sformatf("reset_hold_%0d", k), 0, 1'b0, 1'b0, 2'd0);
    expect_push("reset_hold_b", 1, 1'b0, 1'b0, 2'd0);
    check_next();

    // Release: busy is high after edges 3-5, and clean_out rises after edge 6.
    reset = 1'b0;
    for (int k = 1; k <= 7; k++)
      step($sformatf("release_e%0d", k), 0, k >= 6, (k >= 3) && (k <= 5), 2'd0);

    // Falling glitch: a_in is low for 3 cycles, and the glitch lands on edge 6.
    for (int k = 1; k <= 6; k++) begin
      a_in = (k >= 4);
      step($sformatf("fall_glitch_e%0d", k), 0, 1'b1, (k >= 3) && (k <= 5), (k >= 6) ? 2'd1 : 2'd0);
    end

    // Real fall with a_in held low.
    a_in = 1'b0;
    for (int k = 1; k <= 7; k++)
      step($sformatf("real_fall_e%0d", k), 0, k <= 5, (k >= 3) && (k <= 5), 2'd1);

    // Rising glitch: a_in is high for 2 cycles, so busy pulses after edges 3 and 4.
    for (int k = 1; k <= 6; k++) begin
      a_in = (k <= 2);
      step($sformatf("rise_glitch_e%0d", k), 0, 1'b0, (k >= 3) && (k <= 4), (k >= 5) ? 2'd2 : 2'd1);
    end

    a_clr = 1'b1;
    step("clear_from_2", 0, 1'b0, 1'b0, 2'd0);
    a_clr = 1'b0;

    // Five glitches saturate the counter at 3.
    for (int g = 1; g <= 5; g++) begin
      for (int k = 1; k <= 5; k++) begin
        a_in = (k <= 2);
        if (k < 5) tick();
        else step($sformatf("sat_glitch_%0d", g), 0, 1'b0, 1'b0, (g >= 3) ? 2'd3 : 2'(g));
      end
    end

    // A clear on the same edge as a glitch event gives 1.
    for (int k = 1; k <= 5; k++) begin
      a_in  = (k <= 2);
      a_clr = (k == 5);
      if (k < 5) tick();
      else step("clear_with_glitch", 0, 1'b0, 1'b0, 2'd1);
    end
    a_clr = 1'b1;
    step("clear_pulse", 0, 1'b0, 1'b0, 2'd0);
    a_clr = 1'b0;

    // Reset arrives while the FSM is in CHECK_HIGH.
    a_in = 1'b1;
    tick();
    tick();
    step("midq_busy", 0, 1'b0, 1'b1, 2'd0);
    reset = 1'b1;
    a_in  = 1'b0;
    step("midq_reset", 0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) step($sformatf("midq_after_%0d", k), 0, 1'b0, 1'b0, 2'd0);

    // With STABLE_CYCLES=1, a step rises after edge 3 and busy never asserts.
    b_in = 1'b1;
    for (int k = 1; k <= 4; k++) step($sformatf("s1_step_e%0d", k), 1, k >= 3, 1'b0, 2'd0);
    // A 1-cycle low pulse reaches clean_out after edge 3 only.
    for (int k = 1; k <= 5; k++) begin
      b_in = (k != 1);
      step($sformatf("s1_pulse_e%0d", k), 1, k != 3, 1'b0, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
